// File: rtl/sb_pkg.sv
// Shared types and defaults for the core-side store buffer.
package sb_pkg;
  localparam int SB_DEPTH_DEF = 4;
  localparam int SB_AW        = 32;
  localparam int SB_DW        = 32;

  typedef enum logic {SB_IDLE = 1'b0, SB_REQ = 1'b1} sb_state_t;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic logic [SB_AW-3:0] word_idx(input logic [SB_AW-1:0] a);
    return a[SB_AW-1:2];
  endfunction
endpackage

// File: rtl/store_buffer_fifo.sv
// Store queue storage: circular array, head/tail/count, and per-slot word-address match.
module store_buffer_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                push_addr,
  input  logic [DW-1:0]                push_data,
  input  logic [AW-3:0]                match_widx,
  output logic [DEPTH-1:0][AW-1:0]     ent_addr,
  output logic [DEPTH-1:0][DW-1:0]     ent_data,
  output logic [PW-1:0]                head,
  output logic [CW-1:0]                count,
  output logic [CW-1:0]                count_nxt,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             match
);
  logic [PW-1:0] tail;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointers are PW bits wide, so increments wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= push_addr;
      ent_data[tail] <= push_data;
    end
  end

  // A slot is live when its distance from head is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PW-1:0] off;
    assign off      = PW'(i) - head;
    assign match[i] = ({1'b0, off} < count) && (ent_addr[i][AW-1:2] == match_widx);
  end
endmodule

// File: rtl/store_buffer.sv
// Store buffer between core data port and slow memory: drain FSM, stall and load path.
// Build option: define SB_FORWARD_EN to forward load hits from the buffer instead of stalling.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [AW-1:0] DataAdr,
  input  logic [DW-1:0] WriteData,
  output logic [DW-1:0] ReadData,
  output logic          Stall,
  output logic          sb_empty,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_state_t                  state, state_nxt;
  logic [DEPTH-1:0][AW-1:0]   ent_addr;
  logic [DEPTH-1:0][DW-1:0]   ent_data;
  logic [PW-1:0]              head;
  logic [CW-1:0]              count, count_nxt;
  logic                       full, empty, push, pop, hit, ld_stall;
  logic [DEPTH-1:0]           match;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign push = MemWrite && !full;
  assign pop  = (state == SB_REQ) && mem_ack && !empty;

  store_buffer_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk        (clk),
    .rst_n      (Reset),
    .push       (push),
    .pop        (pop),
    .push_addr  ({DataAdr[AW-1:2], 2'b00}),
    .push_data  (WriteData),
    .match_widx (DataAdr[AW-1:2]),
    .ent_addr   (ent_addr),
    .ent_data   (ent_data),
    .head       (head),
    .count      (count),
    .count_nxt  (count_nxt),
    .full       (full),
    .empty      (empty),
    .match      (match)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      SB_IDLE: if (count != '0)     state_nxt = SB_REQ;
      SB_REQ:  if (count_nxt == '0) state_nxt = SB_IDLE;
      default:                      state_nxt = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state    <= SB_IDLE;
      mem_req  <= 1'b0;
      sb_empty <= 1'b1;
    end else begin
      state    <= state_nxt;
      mem_req  <= (state_nxt == SB_REQ);
      sb_empty <= (count_nxt == '0) && (state_nxt == SB_IDLE);
    end
  end

  // Head entry is stable in REQ: tail cannot reach head while entries are pending.
  assign mem_addr  = (state == SB_REQ) ? ent_addr[head] : '0;
  assign mem_wdata = (state == SB_REQ) ? ent_data[head] : '0;
  assign mem_raddr = DataAdr;
  assign hit       = MemRead && (|match);

`ifdef SB_FORWARD_EN
  logic [DW-1:0] fwd;

  // Walk oldest to youngest; the last live match wins.
  always_comb begin
    fwd = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[PW'(head + PW'(k))]) fwd = ent_data[PW'(head + PW'(k))];
    end
  end

  assign ReadData = hit ? fwd : mem_rdata;
  assign ld_stall = 1'b0;
`else
  assign ReadData = mem_rdata;
  assign ld_stall = hit;
`endif

  assign Stall = (MemWrite && full) || ld_stall;
endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer with a queue-based reference model and drain scoreboard.
module tb_store_buffer;
  import sb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          MemWrite = 1'b0, MemRead = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] DataAdr = '0;
  logic [DW-1:0] WriteData = '0, mem_rdata = '0;
  logic [DW-1:0] ReadData, mem_wdata;
  logic [AW-1:0] mem_addr, mem_raddr;
  logic          Stall, sb_empty, mem_req;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .Reset     (rst_n),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .sb_empty  (sb_empty),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  int        n_cmp = 0, n_err = 0;
  sb_entry_t mq[$];      // entries the model believes are pending, oldest first
  sb_entry_t exp_q[$];   // writes the memory must observe, in order
  sb_entry_t mon_e;
  bit        req_m = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // mem_req is high in a cycle iff the buffer held entries both in that cycle and the one before.
  task automatic step(input bit we, input bit re, input logic [31:0] adr,
                      input logic [31:0] wd, input bit ack);
    bit        hit, full, exp_stall;
    sb_entry_t yng, e;
    int        old;
    logic [31:0] exp_rd;
    MemWrite = we; MemRead = re; DataAdr = adr; WriteData = wd;
    mem_ack = ack; mem_rdata = $urandom;
    @(negedge clk);
    full = (mq.size() == DEPTH);
    hit  = 1'b0;
    yng  = '0;
    foreach (mq[i]) if (word_idx(mq[i].addr) == word_idx(adr)) begin hit = 1'b1; yng = mq[i]; end
    exp_stall = (we && full) || (re && hit && !FWD);
    exp_rd    = (FWD && re && hit) ? yng.data : mem_rdata;
    chk("stall", Stall, exp_stall);
    chk("rdata", ReadData, exp_rd);
    chk("raddr", mem_raddr, adr);
    chk("mem_req", mem_req, req_m);
    chk("sb_empty", sb_empty, mq.size() == 0);
    if (req_m) begin
      chk("mem_addr", mem_addr, mq[0].addr);
      chk("mem_wdata", mem_wdata, mq[0].data);
    end
    @(posedge clk);
    old = mq.size();
    if (req_m && ack) void'(mq.pop_front());
    if (we && !full) begin
      e.addr = {adr[31:2], 2'b00};
      e.data = wd;
      mq.push_back(e);
      exp_q.push_back(e);
    end
    req_m = (old > 0) && (mq.size() > 0);
    #1;
  endtask

  task automatic do_reset();
    MemWrite = 0; MemRead = 0; mem_ack = 0; DataAdr = '0; WriteData = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_sb_empty", sb_empty, 1'b1);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    mq.delete(); exp_q.delete(); req_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Handshake completes on the next rising edge; check and retire it here.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ack) begin
      if (exp_q.size() == 0) chk("drain_extra", 1'b1, 1'b0);
      else begin
        mon_e = exp_q.pop_front();
        chk("drain_addr", mem_addr, mon_e.addr);
        chk("drain_data", mem_wdata, mon_e.data);
      end
    end
  end

  task automatic drain();
    repeat (2 * DEPTH + 2) step(0, 0, 32'h0, 32'h0, 1);
  endtask

  initial begin
    #2;
    do_reset();
    repeat (2) step(0, 0, 32'h0, 32'h0, 0);

    // Reset mid-handshake with three entries pending.
    for (int i = 0; i < 3; i++) step(1, 0, 32'h100 + 4 * i, $urandom, 0);
    step(0, 0, 32'h0, 32'h0, 0);
    do_reset();
    repeat (4) step(0, 0, 32'h0, 32'h0, 1);

    // Fill to DEPTH, stall on the fifth, single ack frees one slot a cycle later.
    for (int i = 0; i < 4; i++) step(1, 0, 32'h10 + 4 * i, 32'hD000 + i, 0);
    step(1, 0, 32'h20, 32'hD020, 0);
    step(1, 0, 32'h20, 32'hD020, 1);
    step(1, 0, 32'h20, 32'hD020, 0);
    drain();

    // Streaming store every cycle with ack held high; pointers wrap repeatedly.
    for (int i = 0; i < 20; i++) step(1, 0, 32'h10 + 4 * i, $urandom, 1);
    drain();

    // Two stores to the same word, then a sub-word load of it.
    step(1, 0, 32'h40, 32'hAAAA0001, 0);
    step(1, 0, 32'h40, 32'hBBBB0002, 0);
    repeat (3) step(0, 1, 32'h42, 32'h0, 0);
    repeat (6) step(0, 1, 32'h42, 32'h0, 1);
    drain();

    // Load miss while buffer holds another word.
    step(1, 0, 32'h40, 32'h12345678, 0);
    repeat (2) step(0, 1, 32'h80, 32'h0, 0);
    drain();

    // Enqueue and pop together at count=2.
    step(1, 0, 32'h200, 32'hA0, 0);
    step(1, 0, 32'h204, 32'hA1, 0);
    step(1, 0, 32'h208, 32'hA2, 1);
    repeat (2) step(0, 0, 32'h0, 32'h0, 0);
    drain();

    // Random traffic over a small address window.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 3);
      if ($urandom_range(0, 99) == 0) do_reset();
      step(r == 1, r == 2, 32'h40 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3),
           $urandom, $urandom_range(0, 2) != 0);
    end
    drain();
    chk("writes_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
